apb_initiator: RTL and testbench
================================

# apb_initiator

Single-outstanding APB3 requester that turns a valid/ready command channel into APB SETUP/ACCESS transfers and returns the read data and error status on a valid/ready response channel. It sits on the initiator side of APB peripherals such as the UART, and serves boot/debug engines and test harnesses that drive peripheral registers without a full interconnect. A programmable timeout aborts transfers whose completer never asserts `pready_i`.

## Interface
- `ADDR_WIDTH`, 32: width of the APB address.
- `DATA_WIDTH`, 32: width of the APB read and write data.
- `TIMEOUT_CYCLES`, 255: maximum number of ACCESS cycles without `pready_i`; 0 disables the timeout.

- `clk_i`  in  1  sole clock; all state changes on the rising edge.
- `rst_i`  in  1  asynchronous, active-high reset.
- `req_valid_i`  in  1  command valid.
- `req_ready_o`  out  1  command accepted when `req_valid_i & req_ready_o`.
- `req_addr_i`  in  ADDR_WIDTH  target address.
- `req_write_i`  in  1  1 = write, 0 = read.
- `req_wdata_i`  in  DATA_WIDTH  write data.
- `rsp_valid_o`  out  1  response valid.
- `rsp_ready_i`  in  1  response consumed.
- `rsp_rdata_o`  out  DATA_WIDTH  read data; 0 for writes and timeouts.
- `rsp_err_o`  out  1  set on `pslverr_i` or on timeout.
- `rsp_timeout_o`  out  1  set only on timeout.
- `psel_o`, `penable_o`, `pwrite_o`  out  1  APB control.
- `paddr_o`  out  ADDR_WIDTH  APB address.
- `pwdata_o`  out  DATA_WIDTH  APB write data.
- `prdata_i`  in  DATA_WIDTH  APB read data.
- `pready_i`, `pslverr_i`  in  1  APB completion and error.

## Operation
- FSM has four states: IDLE, SETUP, ACCESS, RESP. Reset state is IDLE.
- **IDLE**
  - `req_ready_o = 1`; this is the only state in which it is 1.
  - On handshake: register addr, write flag and wdata; go to SETUP.
- **SETUP**
  - `psel_o = 1`, `penable_o = 0`.
  - Unconditionally go to ACCESS after one cycle.
- **ACCESS**
  - `psel_o = 1`, `penable_o = 1`.
  - `paddr_o`, `pwrite_o` and `pwdata_o` stay stable from SETUP until ACCESS exits.
  - Completion when `pready_i = 1`:
    - latch `rsp_rdata_o = prdata_i` for reads, 0 for writes;
    - `rsp_err_o = pslverr_i`, `rsp_timeout_o = 0`;
    - go to RESP.
  - `pslverr_i` and `prdata_i` are ignored on any cycle without `pready_i`.
- **Timeout**
  - A counter of width `$clog2(TIMEOUT_CYCLES+1)` clears on entry to ACCESS and increments on each ACCESS cycle with `pready_i = 0`.
  - When `TIMEOUT_CYCLES != 0` and the counter equals `TIMEOUT_CYCLES - 1` with `pready_i = 0`: abort.
    - `rsp_err_o = 1`, `rsp_timeout_o = 1`, `rsp_rdata_o = 0`; go to RESP.
    - `psel_o` and `penable_o` drop on the next cycle.
  - If `pready_i = 1` arrives on the abort cycle, it wins and the transfer completes normally.
- **RESP**
  - `rsp_valid_o = 1`; response fields held stable until `rsp_ready_i`.
  - On handshake go to IDLE.
  - `rsp_valid_o` never drops without a handshake.
- Outside SETUP and ACCESS: `psel_o = penable_o = 0`. `paddr_o`, `pwrite_o` and `pwdata_o` hold their last values.
- Only one transfer is outstanding at a time. Commands presented outside IDLE wait; they are neither dropped nor duplicated.

## Timing
- Reset values:
  - state IDLE; `psel_o`, `penable_o`, `pwrite_o` = 0; `paddr_o`, `pwdata_o` = 0;
  - `rsp_valid_o`, `rsp_err_o`, `rsp_timeout_o` = 0; `rsp_rdata_o` = 0; timeout counter 0.
- `req_ready_o` is decoded from state and reads 1 during reset. Handshakes while `rst_i` is high have no effect.
- Latency with a zero-wait completer, command handshake on cycle N:
  - N+1 SETUP, N+2 ACCESS with `pready_i` = 1;
  - `rsp_valid_o` = 1 on N+3;
  - response handshake on N+3 allows the next command handshake on N+4.
- Each `pready_i` wait cycle adds exactly one cycle.
- A timeout abort reaches RESP `TIMEOUT_CYCLES` cycles after ACCESS entry.
- Reset asserted mid-transfer, in any state:
  - all outputs take reset values immediately (asynchronous);
  - `psel_o` and `penable_o` drop in the same cycle;
  - the transfer is lost with no response.

## Test plan
- **Zero-wait write:** command `addr=0x1000_000C`, `write=1`, `wdata=0x0000_0083`, `pready_i` tied 1.
  - Response: exactly one SETUP cycle, then one ACCESS cycle carrying `paddr_o=0x1000_000C` and `pwdata_o=0x83`.
  - Then `rsp_valid_o` with `rsp_err_o=0` and `rsp_rdata_o=0`, 3 cycles after accept.
- **Read with 3 wait states:** `addr=0x1000_0014`, `prdata_i=0x0000_0060` on the `pready_i` cycle.
  - Response: ACCESS lasts 4 cycles with stable address; `rsp_rdata_o=0x60`, `rsp_err_o=0`.
- **Slave error:** read with `pslverr_i=1` and `pready_i=1`; separately, `pslverr_i=1` pulsed on a cycle with `pready_i=0`.
  - Response: the first gives `rsp_err_o=1`, `rsp_timeout_o=0`; the second pulse is ignored.
- **Timeout:** `TIMEOUT_CYCLES=4`, `pready_i` held 0.
  - Response: ACCESS for exactly 4 cycles, then `psel_o=0`.
  - `rsp_err_o=1`, `rsp_timeout_o=1`, `rsp_rdata_o=0`.
  - Repeat with `pready_i=1` on the 4th ACCESS cycle: normal completion.
- **Response backpressure:** `rsp_ready_i=0` for 5 cycles while a second command is pending.
  - Response: `rsp_valid_o` and its data stay stable; `req_ready_o=0`.
  - The second command is accepted only in the cycle after the response handshake.
- **Reset mid-ACCESS:** assert `rst_i` during a wait state.
  - Response: `psel_o` and `penable_o` drop in the same cycle; no response is produced.
  - After release, a new write completes normally.

Source files
------------

// File: rtl/apb_initiator.sv
// Single-outstanding APB3 requester: valid/ready command in, APB SETUP/ACCESS out,
// read data and error/timeout status returned on a valid/ready response channel.
module apb_initiator #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                  clk_i,
    input  logic                  rst_i,

    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic                  req_write_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,

    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic                  rsp_timeout_o,

    output logic                  psel_o,
    output logic                  penable_o,
    output logic                  pwrite_o,
    output logic [ADDR_WIDTH-1:0] paddr_o,
    output logic [DATA_WIDTH-1:0] pwdata_o,
    input  logic [DATA_WIDTH-1:0] prdata_i,
    input  logic                  pready_i,
    input  logic                  pslverr_i
);

    // A zero TIMEOUT_CYCLES still needs a legal (1-bit) counter; it is simply never compared.
    localparam bit TimeoutEn = (TIMEOUT_CYCLES != 0);
    localparam int unsigned CntW = TimeoutEn ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CntW-1:0] CntLast = TimeoutEn ? CntW'(TIMEOUT_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StAccess,
        StResp
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic                  pwrite_q, pwrite_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic                  tmo_q, tmo_d;
    logic [CntW-1:0]       cnt_q, cnt_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            paddr_q  <= '0;
            pwrite_q <= 1'b0;
            pwdata_q <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            tmo_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            paddr_q  <= paddr_d;
            pwrite_q <= pwrite_d;
            pwdata_q <= pwdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            tmo_q    <= tmo_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        paddr_d  = paddr_q;
        pwrite_d = pwrite_q;
        pwdata_d = pwdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        tmo_d    = tmo_q;
        cnt_d    = cnt_q;

        unique case (state_q)
            StIdle: begin
                if (req_valid_i) begin
                    paddr_d  = req_addr_i;
                    pwrite_d = req_write_i;
                    pwdata_d = req_wdata_i;
                    state_d  = StSetup;
                end
            end
            StSetup: begin
                cnt_d   = '0;
                state_d = StAccess;
            end
            StAccess: begin
                // pready_i on the would-be abort cycle takes priority over the timeout.
                if (pready_i) begin
                    rdata_d = pwrite_q ? '0 : prdata_i;
                    err_d   = pslverr_i;
                    tmo_d   = 1'b0;
                    state_d = StResp;
                end else if (TimeoutEn && (cnt_q == CntLast)) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    tmo_d   = 1'b1;
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StResp: begin
                if (rsp_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign req_ready_o   = (state_q == StIdle);
    assign psel_o        = (state_q == StSetup) || (state_q == StAccess);
    assign penable_o     = (state_q == StAccess);
    assign pwrite_o      = pwrite_q;
    assign paddr_o       = paddr_q;
    assign pwdata_o      = pwdata_q;
    assign rsp_valid_o   = (state_q == StResp);
    assign rsp_rdata_o   = rdata_q;
    assign rsp_err_o     = err_q;
    assign rsp_timeout_o = tmo_q;

    property p_rsp_hold;
        @(posedge clk_i) disable iff (rst_i)
        (rsp_valid_o && !rsp_ready_i) |=> (rsp_valid_o && $stable(rsp_rdata_o)
                                           && $stable(rsp_err_o) && $stable(rsp_timeout_o));
    endproperty
    a_rsp_hold: assert property (p_rsp_hold);

    property p_setup_to_access;
        @(posedge clk_i) disable iff (rst_i)
        (psel_o && !penable_o) |=> (psel_o && penable_o);
    endproperty
    a_setup_to_access: assert property (p_setup_to_access);

    property p_access_stable;
        @(posedge clk_i) disable iff (rst_i)
        penable_o |-> ($stable(paddr_o) && $stable(pwrite_o) && $stable(pwdata_o));
    endproperty
    a_access_stable: assert property (p_access_stable);

endmodule

// File: tb/tb_apb_initiator.sv
// Scoreboard bench for apb_initiator: directed cases from the test plan plus randomized traffic.
module tb_apb_initiator;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 4;

    logic          clk       = 1'b0;
    logic          rst       = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [AW-1:0] req_addr  = '0;
    logic          req_write = 1'b0;
    logic [DW-1:0] req_wdata = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          rsp_timeout;
    logic          psel;
    logic          penable;
    logic          pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic [DW-1:0] prdata    = '0;
    logic          pready    = 1'b0;
    logic          pslverr   = 1'b0;

    apb_initiator #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_addr_i   (req_addr),
        .req_write_i  (req_write),
        .req_wdata_i  (req_wdata),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_rdata_o  (rsp_rdata),
        .rsp_err_o    (rsp_err),
        .rsp_timeout_o(rsp_timeout),
        .psel_o       (psel),
        .penable_o    (penable),
        .pwrite_o     (pwrite),
        .paddr_o      (paddr),
        .pwdata_o     (pwdata),
        .prdata_i     (prdata),
        .pready_i     (pready),
        .pslverr_i    (pslverr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic          write;
        logic [DW-1:0] wdata;
        int            waits;   // ACCESS cycles the completer stalls before pready
        logic          slverr;
        logic [DW-1:0] rdata;
    } cmd_t;

    typedef struct {
        logic [DW-1:0] rdata;
        logic          err;
        logic          tmo;
        int            len;     // ACCESS cycles
        int            lat;     // accept cycle to first rsp_valid cycle
    } rsp_t;

    cmd_t cmd_q[$];
    rsp_t exp_q[$];
    int   acc_q[$];
    int   setup_idx = 0;
    int   cyc       = 0;
    int   last_hs   = -1;
    int   errors    = 0;
    int   checks    = 0;
    bit   rand_rdy  = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_event(input string name);
        checks++;
        errors++;
        $display("FAIL %s: required event missing or unexpected", name);
    endtask

    // Reference behaviour: timeout once the completer stalls TO or more ACCESS cycles.
    function automatic rsp_t model(input cmd_t c);
        rsp_t r;
        bit   tmo;
        tmo     = (TO != 0) && (c.waits >= int'(TO));
        r.tmo   = tmo;
        r.err   = tmo ? 1'b1 : c.slverr;
        r.rdata = (tmo || c.write) ? '0 : c.rdata;
        r.len   = tmo ? int'(TO) : c.waits + 1;
        r.lat   = r.len + 2;
        return r;
    endfunction

    function automatic cmd_t mk(input logic [AW-1:0] addr, input logic write,
                                input logic [DW-1:0] wdata, input int waits,
                                input logic slverr, input logic [DW-1:0] rdata);
        cmd_t c;
        c.addr   = addr;
        c.write  = write;
        c.wdata  = wdata;
        c.waits  = waits;
        c.slverr = slverr;
        c.rdata  = rdata;
        return c;
    endfunction

    task automatic start_req(input cmd_t c);
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_addr  = c.addr;
        req_write = c.write;
        req_wdata = c.wdata;
        cmd_q.push_back(c);
        exp_q.push_back(model(c));
    endtask

    task automatic wait_accept(output int acc);
        int n;
        n   = 0;
        acc = -1;
        forever begin
            @(negedge clk);
            if (!rst && req_ready) begin
                acc = cyc;
                break;
            end
            n++;
            if (n >= 200) begin
                fail_event("accept_timeout");
                break;
            end
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic issue(input cmd_t c);
        int acc;
        start_req(c);
        wait_accept(acc);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) fail_event("drain_timeout");
        repeat (2) @(negedge clk);
    endtask

    initial begin : rdy_gen
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) rsp_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Completer model: stalls per command, checks APB phase ordering and stability.
    initial begin : completer
        cmd_t cur;
        int   k;
        bit   prev_setup, prev_access, have;
        k           = 0;
        prev_setup  = 1'b0;
        prev_access = 1'b0;
        have        = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            pready  = 1'b0;
            pslverr = 1'($urandom_range(0, 1));
            prdata  = $urandom;
            if (rst) begin
                prev_setup  = 1'b0;
                prev_access = 1'b0;
                have        = 1'b0;
                continue;
            end
            if (prev_setup) check("setup_one_cycle", 64'(psel && penable), 64'h1);
            if (prev_access && !(psel && penable) && have) begin
                check("access_len", 64'(k), 64'(model(cur).len));
                check("psel_drop", 64'(psel), 64'h0);
            end
            if (psel && !penable) begin
                if (setup_idx < cmd_q.size()) begin
                    cur = cmd_q[setup_idx];
                    setup_idx++;
                    have = 1'b1;
                end else begin
                    fail_event("setup_without_cmd");
                    have = 1'b0;
                end
                k = 0;
            end
            if (psel && penable && have) begin
                check("paddr", 64'(paddr), 64'(cur.addr));
                check("pwrite", 64'(pwrite), 64'(cur.write));
                check("pwdata", 64'(pwdata), 64'(cur.wdata));
                if (k == cur.waits) begin
                    pready  = 1'b1;
                    pslverr = cur.slverr;
                    prdata  = cur.rdata;
                end else if (k == 0) begin
                    pslverr = 1'b1;
                end
                k++;
            end
            prev_setup  = psel && !penable;
            prev_access = psel && penable;
        end
    end

    // Response monitor: pops the scoreboard on each response handshake.
    initial begin : monitor
        rsp_t          e;
        bit            held;
        logic [DW-1:0] h_rdata;
        logic          h_err, h_tmo;
        held    = 1'b0;
        h_rdata = '0;
        h_err   = 1'b0;
        h_tmo   = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                held = 1'b0;
                continue;
            end
            if (req_valid && req_ready) acc_q.push_back(cyc);
            if (rsp_valid) begin
                check("req_ready_in_resp", 64'(req_ready), 64'h0);
                if (held) begin
                    check("hold_rdata", 64'(rsp_rdata), 64'(h_rdata));
                    check("hold_err", 64'(rsp_err), 64'(h_err));
                    check("hold_tmo", 64'(rsp_timeout), 64'(h_tmo));
                end else if (exp_q.size() == 0 || acc_q.size() == 0) begin
                    fail_event("unexpected_response");
                end else begin
                    check("latency", 64'(cyc - acc_q[0]), 64'(exp_q[0].lat));
                end
                if (rsp_ready) begin
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
                        check("rsp_err", 64'(rsp_err), 64'(e.err));
                        check("rsp_timeout", 64'(rsp_timeout), 64'(e.tmo));
                    end
                    if (acc_q.size() != 0) void'(acc_q.pop_front());
                    last_hs = cyc;
                    held    = 1'b0;
                end else begin
                    held    = 1'b1;
                    h_rdata = rsp_rdata;
                    h_err   = rsp_err;
                    h_tmo   = rsp_timeout;
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        cmd_t c;
        int   acc;
        int   n;

        #2;
        check("rst_req_ready", 64'(req_ready), 64'h1);
        check("rst_psel", 64'(psel), 64'h0);
        check("rst_penable", 64'(penable), 64'h0);
        check("rst_pwrite", 64'(pwrite), 64'h0);
        check("rst_paddr", 64'(paddr), 64'h0);
        check("rst_pwdata", 64'(pwdata), 64'h0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'h0);
        check("rst_rsp_err", 64'(rsp_err), 64'h0);
        check("rst_rsp_tmo", 64'(rsp_timeout), 64'h0);
        check("rst_rsp_rdata", 64'(rsp_rdata), 64'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst       = 1'b0;
        rsp_ready = 1'b1;

        // Zero-wait write, 3-wait read, slave error, ignored error pulse, timeout and near-timeout.
        issue(mk(32'h1000_000C, 1'b1, 32'h0000_0083, 0, 1'b0, 32'hDEAD_BEEF));
        drain();
        issue(mk(32'h1000_0014, 1'b0, 32'h5555_5555, 3, 1'b0, 32'h0000_0060));
        drain();
        issue(mk(32'h1000_0018, 1'b0, 32'h0, 0, 1'b1, 32'hCAFE_0001));
        drain();
        issue(mk(32'h1000_001C, 1'b0, 32'h0, 2, 1'b0, 32'h1234_5678));
        drain();
        issue(mk(32'h2000_0000, 1'b0, 32'h0, 50, 1'b0, 32'hFFFF_FFFF));
        drain();
        issue(mk(32'h2000_0004, 1'b1, 32'hA5A5_A5A5, 20, 1'b1, 32'hFFFF_FFFF));
        drain();
        issue(mk(32'h2000_0008, 1'b0, 32'h0, 3, 1'b0, 32'h0000_00A5));
        drain();

        // Response backpressure with a second command pending.
        rsp_ready = 1'b0;
        issue(mk(32'h3000_0000, 1'b0, 32'h0, 0, 1'b0, 32'h0BAD_F00D));
        start_req(mk(32'h3000_0004, 1'b1, 32'h7777_0000, 1, 1'b0, 32'h0));
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid && n < 20);
        if (!rsp_valid) fail_event("bp_rsp_valid");
        repeat (5) @(negedge clk);
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        wait_accept(acc);
        check("bp_accept_after_hs", 64'(acc - last_hs), 64'h1);
        drain();

        // Reset during an ACCESS wait state.
        issue(mk(32'h4000_0000, 1'b0, 32'h0, 10, 1'b0, 32'h1111_1111));
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("pre_rst_access", 64'(psel && penable), 64'h1);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_psel", 64'(psel), 64'h0);
        check("midrst_penable", 64'(penable), 64'h0);
        check("midrst_rsp_valid", 64'(rsp_valid), 64'h0);
        check("midrst_paddr", 64'(paddr), 64'h0);
        check("midrst_req_ready", 64'(req_ready), 64'h1);
        cmd_q.delete();
        exp_q.delete();
        acc_q.delete();
        setup_idx = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        issue(mk(32'h4000_0010, 1'b1, 32'h0000_0042, 1, 1'b0, 32'h0));
        drain();

        // Randomized traffic with random response backpressure.
        rand_rdy = 1'b1;
        for (int i = 0; i < 40; i++) begin
            c = mk($urandom, 1'($urandom_range(0, 1)), $urandom, int'($urandom_range(0, 6)),
                   1'($urandom_range(0, 3) == 0), $urandom);
            issue(c);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
        @(negedge clk);
        rand_rdy  = 1'b0;
        rsp_ready = 1'b1;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
